// File: rtl/mem_responder.sv
// Fixed-latency word memory answering CPU MemRead/MemWrite requests.
// Optional request checking: define MEMRESP_ERR_CHECK_EN.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  bad_q;
  logic                  req;
  logic                  accept;
  logic                  bad_in;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req    = mem_read | mem_write;
  assign accept = (state_q == IDLE) & req;

`ifdef MEMRESP_ERR_CHECK_EN
  assign bad_in = (addr[1:0] != 2'b00)
                | ((addr >> (IW + 2)) != 32'd0)
                | (mem_read & mem_write);
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign bad_in      = 1'b0;
`endif

  // State and countdown registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; inputs are only looked at when accepting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= addr[IW+1:2];
      wdata_q <= din;
      wr_q    <= mem_write;
      bad_q   <= bad_in;
    end
  end

  // Next state: count down LATENCY-1 edges, then one RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write commits on the edge leaving RESP; array is never reset
  always_ff @(posedge clk) begin
    if (ready && wr_q && !bad_q) mem[idx_q] <= wdata_q;
  end

  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign err   = ready & bad_q;
  assign dout  = (ready & ~wr_q & ~bad_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 1, 2 and 3.
// Instance k has LATENCY k+1 and DEPTH 16.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rd;
  logic [2:0]  wr;
  logic [2:0]  rdy;
  logic [2:0]  bsy;
  logic [2:0]  er;
  logic [31:0] ad [3];
  logic [31:0] di [3];
  logic [31:0] dq [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .DATA_WIDTH(32),
      .DEPTH     (16),
      .LATENCY   (g + 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .mem_read (rd[g]),
      .mem_write(wr[g]),
      .addr     (ad[g]),
      .din      (di[g]),
      .dout     (dq[g]),
      .ready    (rdy[g]),
      .busy     (bsy[g]),
      .err      (er[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One request on instance k; returns dout/err at ready
  task automatic xact(input string nm, input int k, input bit w,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] q, output logic e);
    int lat;
    @(negedge clk);
    rd[k] = !w;
    wr[k] = w;
    ad[k] = a;
    di[k] = d;
    @(posedge clk);
    #1;
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    chk({nm, ".busy_acc"}, 32'(bsy[k]), 32'd1);
    lat = 0;
    while (!rdy[k] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, ".lat"}, 32'(lat), 32'(k));
    q = dq[k];
    e = er[k];
    @(posedge clk);
    #1;
    chk({nm, ".rdy_end"}, 32'(rdy[k]), 32'd0);
    chk({nm, ".busy_end"}, 32'(bsy[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    logic [5:0]  rp;
    logic [5:0]  bp;
    int          seen;

    reset = 1'b0;
    rd    = '0;
    wr    = '0;
    for (int i = 0; i < 3; i++) begin
      ad[i] = '0;
      di[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(rdy[1]), 32'd0);
    chk("rst.busy", 32'(bsy[1]), 32'd0);
    chk("rst.dout", dq[1], 32'd0);
    chk("rst.err", 32'(er[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Write then read, LATENCY 2
    xact("wr10", 1, 1'b1, 32'h10, 32'hDEADBEEF, q, e);
    chk("wr10.dout", q, 32'd0);
    chk("wr10.err", 32'(e), 32'd0);
    xact("rd10", 1, 1'b0, 32'h10, 32'h0, q, e);
    chk("rd10.dout", q, 32'hDEADBEEF);
    chk("rd10.err", 32'(e), 32'd0);

    // LATENCY 1, read held high back to back
    xact("wr0_l1", 0, 1'b1, 32'h0, 32'h13579BDF, q, e);
    @(negedge clk);
    rd[0] = 1'b1;
    ad[0] = 32'h0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      rp[i] = rdy[0];
      bp[i] = bsy[0];
      if (rdy[0]) chk("b2b.dout", dq[0], 32'h13579BDF);
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    rd[0] = 1'b0;
    chk("b2b.ready", 32'(rp), 32'b010101);
    chk("b2b.busy", 32'(bp), 32'b010101);
    repeat (3) @(posedge clk);

    // Inputs changed during WAIT are ignored
    xact("wr20", 1, 1'b1, 32'h20, 32'h11111111, q, e);
    xact("wr24", 1, 1'b1, 32'h24, 32'h22222222, q, e);
    @(negedge clk);
    rd[1] = 1'b1;
    ad[1] = 32'h20;
    @(posedge clk);
    #1;
    ad[1] = 32'h24;
    wr[1] = 1'b1;
    di[1] = 32'h33333333;
    @(posedge clk);
    #1;
    chk("mid.ready", 32'(rdy[1]), 32'd1);
    chk("mid.dout", dq[1], 32'h11111111);
    chk("mid.err", 32'(er[1]), 32'd0);
    rd[1] = 1'b0;
    wr[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.busy_end", 32'(bsy[1]), 32'd0);
    xact("rd24", 1, 1'b0, 32'h24, 32'h0, q, e);
    chk("rd24.dout", q, 32'h22222222);

    // Reset during a LATENCY 3 write drops the write
    xact("wr8", 2, 1'b1, 32'h8, 32'hAAAA5555, q, e);
    @(negedge clk);
    wr[2] = 1'b1;
    ad[2] = 32'h8;
    di[2] = 32'h5;
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    chk("rstm.busy_acc", 32'(bsy[2]), 32'd1);
    @(posedge clk);
    #1;
    chk("rstm.ready_pre", 32'(rdy[2]), 32'd0);
    reset = 1'b0;
    #1;
    chk("rstm.busy", 32'(bsy[2]), 32'd0);
    chk("rstm.ready", 32'(rdy[2]), 32'd0);
    chk("rstm.dout", dq[2], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rdy[2]) seen++;
    end
    chk("rstm.no_ready", 32'(seen), 32'd0);
    xact("rd8", 2, 1'b0, 32'h8, 32'h0, q, e);
    chk("rd8.dout", q, 32'hAAAA5555);

    // Misaligned and out-of-range addresses
    xact("wr4", 1, 1'b1, 32'h4, 32'h44444444, q, e);
    xact("wr0", 1, 1'b1, 32'h0, 32'h0A0A0A0A, q, e);
    xact("rd6", 1, 1'b0, 32'h6, 32'h0, q, e);
`ifdef MEMRESP_ERR_CHECK_EN
    chk("rd6.dout", q, 32'd0);
    chk("rd6.err", 32'(e), 32'd1);
`else
    chk("rd6.dout", q, 32'h44444444);
    chk("rd6.err", 32'(e), 32'd0);
`endif
    xact("rd40", 1, 1'b0, 32'h40, 32'h0, q, e);
`ifdef MEMRESP_ERR_CHECK_EN
    chk("rd40.dout", q, 32'd0);
    chk("rd40.err", 32'(e), 32'd1);
`else
    chk("rd40.dout", q, 32'h0A0A0A0A);
    chk("rd40.err", 32'(e), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
